// File: rtl/timer_arb_pkg.sv
// Shared types for the round-robin timer arbiter: FSM state encoding.
package timer_arb_pkg;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_RUN_ENC  = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE_ENC,
    RUN  = ST_RUN_ENC,
    DONE = ST_DONE_ENC
  } state_t;

endpackage

// File: rtl/countdown_core.sv
// Loadable down-counter shared by all requesters; load beats en, never wraps below 0.
module countdown_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] result,
  output logic             is_one
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result <= '0;
    end else if (load) begin
      result <= load_val;
    end else if (en && (result != '0)) begin
      result <= result - WIDTH'(1);
    end
  end

  assign is_one = (result == WIDTH'(1));

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin owner selection plus IDLE/RUN/DONE sequencing around one shared countdown.
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0][WIDTH-1:0] dur,
  input  logic                       en,
  input  logic                       abort,
  output logic [NREQ-1:0]            grant,
  output logic [NREQ-1:0]            done,
  output logic                       busy,
  output logic [WIDTH-1:0]           count,
  output state_t                     fsm_state
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // req is a level, not a valid/ready pair: it is only looked at in IDLE, and
  // grant stays asserted for the whole slot regardless of what req does later.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IDXW-1:0] last_idx);
    logic [IDXW-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_idx) + i) % NREQ;
      if (!found && r[idx]) begin
        pick  = IDXW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  state_t          state, next_state;
  logic [NREQ-1:0] grant_next;
  logic [IDXW-1:0] last, last_next, win;
  logic [NREQ-1:0] win_onehot;
  logic            load, dec_en, is_one;

  assign win = rr_pick(req, last);

  always_comb begin
    win_onehot      = '0;
    win_onehot[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      last  <= IDXW'(NREQ - 1);
    end else begin
      state <= next_state;
      grant <= grant_next;
      last  <= last_next;
    end
  end

  always_comb begin
    next_state = state;
    grant_next = grant;
    last_next  = last;
    load       = 1'b0;
    dec_en     = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          load       = 1'b1;
          grant_next = win_onehot;
          last_next  = win;
          next_state = (dur[win] != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        // abort outranks both the decrement and the RUN->DONE step
        if (abort) begin
          next_state = IDLE;
          grant_next = '0;
        end else if (en) begin
          dec_en = 1'b1;
          if (is_one) next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
        grant_next = '0;
      end
      default: begin
        next_state = IDLE;
        grant_next = '0;
      end
    endcase
  end

  countdown_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (dur[win]),
    .en       (dec_en),
    .result   (count),
    .is_one   (is_one)
  );

  assign done      = (state == DONE) ? grant : '0;
  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter with hand-computed expectations.
module tb_timer_arbiter;
  import timer_arb_pkg::*;

  logic            clk;
  logic            reset;
  logic [3:0]      req;
  logic [3:0][7:0] dur;
  logic            en;
  logic            abort;
  logic [3:0]      grant;
  logic [3:0]      done;
  logic            busy;
  logic [7:0]      count;
  state_t          fsm_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];

  timer_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .dur       (dur),
    .en        (en),
    .abort     (abort),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .count     (count),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'h0);
    check({tag, "_done"},  32'(done),  32'h0);
    check({tag, "_busy"},  32'(busy),  32'h0);
    check({tag, "_state"}, 32'(fsm_state), 32'(IDLE));
  endtask

  initial begin
    logic [7:0] exp_cnt[4];
    logic [3:0] exp_g;

    reset = 1'b0; req = '0; en = 1'b0; abort = 1'b0;
    dur = '0;
    step(2);
    check("rst_count", 32'(count), 32'h0);
    check_idle("rst");
    reset = 1'b1;
    step(1);

    // single slot, dur=3; owner drops req after grant
    dur[0] = 8'd3;
    dur[1] = 8'($urandom_range(1, 255));
    dur[2] = 8'($urandom_range(1, 255));
    dur[3] = 8'($urandom_range(1, 255));
    req = 4'b0001; en = 1'b1;
    exp_cnt = '{8'd3, 8'd2, 8'd1, 8'd0};
    step(1);
    req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      check("t2_grant", 32'(grant), 32'h1);
      check("t2_count", 32'(count), 32'(exp_cnt[i]));
      check("t2_done",  32'(done),  (i == 3) ? 32'h1 : 32'h0);
      if (i < 3) step(1);
    end
    step(1);
    check_idle("t2_end");
    check("t2_hold", 32'(count), 32'h0);

    // round robin from fresh reset, all requesters, dur=1
    reset = 1'b0; step(1); reset = 1'b1;
    dur = {8'd1, 8'd1, 8'd1, 8'd1};
    req = 4'b1111;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    while (exp_q.size() > 0) begin
      exp_g = exp_q.pop_front();
      step(1);
      check("t3_grant", 32'(grant), 32'(exp_g));
      check("t3_run",   32'(fsm_state), 32'(RUN));
      step(1);
      check("t3_done",  32'(done), 32'(exp_g));
      check("t3_cnt0",  32'(count), 32'h0);
      step(1);
      if (exp_q.size() == 0) req = 4'b0000;
      check("t3_bubble", 32'(grant), 32'h0);
    end

    // dur=0 goes straight to DONE (pointer at 0, only req[2])
    dur[2] = 8'd0;
    req = 4'b0100;
    step(1);
    req = 4'b0000;
    check("t4_grant", 32'(grant), 32'h4);
    check("t4_done",  32'(done),  32'h4);
    check("t4_state", 32'(fsm_state), 32'(DONE));
    step(1);
    check_idle("t4_end");

    // pause: dur=4 on req[3], en low 3 cycles after first decrement
    dur[3] = 8'd4;
    req = 4'b1000; en = 1'b1;
    step(1);
    req = 4'b0000;
    check("t5_grant", 32'(grant), 32'h8);
    check("t5_load",  32'(count), 32'd4);
    step(1);
    check("t5_dec1", 32'(count), 32'd3);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("t5_hold", 32'(count), 32'd3);
      check("t5_nodone", 32'(done), 32'h0);
    end
    en = 1'b1;
    step(1); check("t5_c2", 32'(count), 32'd2);
    step(1); check("t5_c1", 32'(count), 32'd1);
    check("t5_early", 32'(done), 32'h0);
    step(1);
    check("t5_done", 32'(done), 32'h8);
    step(1);
    check_idle("t5_end");

    // abort at count=2, then round robin continues from the aborted owner
    dur[0] = 8'd4;
    req = 4'b0001;
    step(1);
    req = 4'b0000;
    check("t6_grant", 32'(grant), 32'h1);
    step(2);
    check("t6_c2", 32'(count), 32'd2);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check_idle("t6_abort");
    check("t6_cnt_hold", 32'(count), 32'd2);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("t6_idle_abort", 32'(count), 32'd2);
    dur[1] = 8'd2;
    req = 4'b0011;
    step(1);
    req = 4'b0000;
    check("t6_next", 32'(grant), 32'h2);
    check("t6_load", 32'(count), 32'd2);
    step(1);
    check("t6_c1", 32'(count), 32'd1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check_idle("t6_abort_prio");
    check("t6_c1_hold", 32'(count), 32'd1);

    // async reset mid-RUN (pointer at 1, so req[2] wins)
    dur[2] = 8'd5;
    req = 4'b0100;
    step(1);
    check("t1_grant", 32'(grant), 32'h4);
    check("t1_count", 32'(count), 32'd5);
    reset = 1'b0;
    #1;
    check("t1_rcount", 32'(count), 32'h0);
    check_idle("t1_rst");
    reset = 1'b1;
    req = 4'b1111;
    dur = {8'd2, 8'd2, 8'd2, 8'd2};
    step(1);
    req = 4'b0000;
    check("t1_first", 32'(grant), 32'h1);
    check("t1_load",  32'(count), 32'd2);
    step(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
